// File: rtl/core_pkg.sv
// Shared core types: dispatch-queue sizing and the uop payload carried from decode
// to the reservation station.
package core_pkg;

  localparam int unsigned RS_ENTRIES = 4;
  localparam int unsigned NUM_FUS    = 2;
  localparam int unsigned DQ_DEPTH   = 8;
  localparam int unsigned DQ_MASK_W  = RS_ENTRIES * NUM_FUS;

  localparam int unsigned OP_W      = 6;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned IMM_W     = 32;
  localparam int unsigned ROB_TAG_W = 6;

  typedef struct packed {
    logic [DQ_MASK_W-1:0] dep_mask;
    logic [OP_W-1:0]      op;
    logic [REG_W-1:0]     rd;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [IMM_W-1:0]     imm;
    logic [ROB_TAG_W-1:0] rob_tag;
  } dq_entry_t;

endpackage

// File: rtl/dq_storage.sv
// Dispatch-queue payload array: one synchronous write port, one asynchronous read port.
// Contents are never reset; the control logic only reads slots it has written.
module dq_storage
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = DQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  dq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output dq_entry_t                rdata
);

  dq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue between decode and the reservation station: first-word
// fall-through head, flush to empty, and a saturating count of RS-backpressure cycles.
module dispatch_queue
  import core_pkg::*;
#(
  parameter int unsigned DEPTH  = DQ_DEPTH,
  parameter int unsigned MASK_W = RS_ENTRIES * NUM_FUS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  input  dq_entry_t                  enq_entry,
  output logic                       enq_ready,
  output logic                       disp_valid,
  output dq_entry_t                  disp_entry,
  output logic [MASK_W-1:0]          dependency_mask,
  input  logic                       rs_full,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                stall_cycles
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      stall_q, stall_d;

  logic enq_fire;
  logic deq_fire;
  logic wr_en;

  // Ready/valid depend only on registered occupancy: no full- or empty-bypass.
  assign enq_ready  = (count_q < CNT_W'(DEPTH));
  assign disp_valid = (count_q != '0);
  assign enq_fire   = enq_valid && enq_ready;
  assign deq_fire   = disp_valid && !rs_full;
  assign wr_en      = enq_fire && !flush && !rst;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = stall_q;

    // Stall accounting is independent of flush so mispredicts don't hide backpressure.
    if (disp_valid && rs_full && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (deq_fire) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  dq_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (wr_en),
    .waddr(tail_q),
    .wdata(enq_entry),
    .raddr(head_q),
    .rdata(disp_entry)
  );

  assign dependency_mask = MASK_W'(disp_entry.dep_mask);
  assign count           = count_q;
  assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: fill/full, full+dequeue, wrapped streaming order,
// flush priority and mid-run reset, checked against hand-computed values and a tag queue.
module tb_dispatch_queue;
  import core_pkg::*;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned MASK_W = RS_ENTRIES * NUM_FUS;

  logic              clk;
  logic              rst;
  logic              enq_valid;
  dq_entry_t         enq_entry;
  logic              enq_ready;
  logic              disp_valid;
  dq_entry_t         disp_entry;
  logic [MASK_W-1:0] dependency_mask;
  logic              rs_full;
  logic              flush;
  logic [3:0]        count;
  logic [31:0]       stall_cycles;

  int n_vec;
  int n_bad;
  int mq[$];
  logic [31:0] mstall;

  dispatch_queue #(
    .DEPTH (DEPTH),
    .MASK_W(MASK_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enq_valid      (enq_valid),
    .enq_entry      (enq_entry),
    .enq_ready      (enq_ready),
    .disp_valid     (disp_valid),
    .disp_entry     (disp_entry),
    .dependency_mask(dependency_mask),
    .rs_full        (rs_full),
    .flush          (flush),
    .count          (count),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic dq_entry_t mk(input int tag, input int mask);
    dq_entry_t e;
    e         = '0;
    e.dep_mask = DQ_MASK_W'(mask);
    e.op       = OP_W'(tag + 1);
    e.rd       = REG_W'(tag);
    e.rs1      = REG_W'(tag + 2);
    e.rs2      = REG_W'(tag + 3);
    e.imm      = IMM_W'(tag * 3 + 7);
    e.rob_tag  = ROB_TAG_W'(tag);
    return e;
  endfunction

  // Advance one clock; the tag queue tracks what the DUT should hold afterwards.
  task automatic tick();
    bit enq;
    bit deq;
    if (rst) begin
      mq.delete();
      mstall = '0;
    end else begin
      if (mq.size() != 0 && rs_full && mstall != 32'hffff_ffff) mstall++;
      if (flush) begin
        mq.delete();
      end else begin
        deq = (mq.size() != 0) && !rs_full;
        enq = enq_valid && (mq.size() < DEPTH);
        if (deq) void'(mq.pop_front());
        if (enq) mq.push_back(int'(enq_entry.rob_tag));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tx;
    int rx;
    n_vec     = 0;
    n_bad     = 0;
    mstall    = '0;
    rst       = 1'b1;
    enq_valid = 1'b0;
    enq_entry = '0;
    rs_full   = 1'b0;
    flush     = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_count", 64'(count), 64'd0);
    check("rst_disp_valid", 64'(disp_valid), 64'd0);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_stall", 64'(stall_cycles), 64'd0);

    // Single entry: not offered in its enqueue cycle, offered the next.
    enq_valid = 1'b1;
    enq_entry = mk(50, 3);
    check("a_valid_cycle_n", 64'(disp_valid), 64'd0);
    tick();
    enq_valid = 1'b0;
    check("a_valid_cycle_n1", 64'(disp_valid), 64'd1);
    check("a_dep_mask", 64'(dependency_mask), 64'h3);
    check("a_rob_tag", 64'(disp_entry.rob_tag), 64'd50);
    tick();
    check("a_drained", 64'(count), 64'd0);

    // Fill to full under backpressure; head must stay put.
    rs_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      enq_valid = 1'b1;
      enq_entry = mk(i, i + 16);
      tick();
      check("fill_head_tag", 64'(disp_entry.rob_tag), 64'd0);
    end
    check("full_count", 64'(count), 64'd8);
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    check("full_stall", 64'(stall_cycles), 64'd7);
    check("full_head_mask", 64'(dependency_mask), 64'h10);
    enq_entry = mk(63, 0);
    tick();
    check("over_count", 64'(count), 64'd8);
    check("over_stall", 64'(stall_cycles), 64'd8);
    check("over_head_stable", 64'(disp_entry.imm), 64'd7);

    // Full with an enqueue attempt and a dequeue: only the dequeue happens.
    enq_entry = mk(8, 24);
    rs_full   = 1'b0;
    tick();
    check("fulldq_count", 64'(count), 64'd7);
    check("fulldq_head", 64'(disp_entry.rob_tag), 64'd1);
    check("fulldq_ready", 64'(enq_ready), 64'd1);
    rs_full = 1'b1;
    tick();
    enq_valid = 1'b0;
    check("retry_count", 64'(count), 64'd8);
    check("retry_stall", 64'(stall_cycles), 64'd9);

    // Drain across the pointer wrap: tags 1..8, rejected tag 63 never appears.
    rs_full = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("drain_tag", 64'(disp_entry.rob_tag), 64'(i));
      tick();
    end
    check("drain_empty", 64'(disp_valid), 64'd0);

    // Streaming with random backpressure, checked against the tag queue.
    tx = 0;
    rx = 0;
    for (int c = 0; c < 400 && rx < 20; c++) begin
      enq_valid = (tx < 20);
      enq_entry = mk(tx, tx);
      rs_full   = 1'($urandom_range(0, 1));
      check("stream_ready", 64'(enq_ready), 64'(mq.size() < DEPTH));
      if (mq.size() != 0 && !rs_full) begin
        check("stream_order", 64'(disp_entry.rob_tag), 64'(rx));
        rx++;
      end
      if (enq_valid && mq.size() < DEPTH) tx++;
      tick();
    end
    enq_valid = 1'b0;
    rs_full   = 1'b0;
    check("stream_done", 64'(rx), 64'd20);
    check("stream_stall", 64'(stall_cycles), 64'(mstall));

    // Flush beats a same-cycle enqueue; stall count survives.
    rs_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      enq_valid = 1'b1;
      enq_entry = mk(40 + i, 1);
      tick();
    end
    check("pre_flush_count", 64'(count), 64'd5);
    flush     = 1'b1;
    enq_entry = mk(60, 2);
    tick();
    flush     = 1'b0;
    enq_valid = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(disp_valid), 64'd0);
    check("flush_stall_kept", 64'(stall_cycles), 64'(mstall));
    rs_full   = 1'b0;
    enq_valid = 1'b1;
    enq_entry = mk(51, 4);
    tick();
    enq_valid = 1'b0;
    check("post_flush_head", 64'(disp_entry.rob_tag), 64'd51);
    tick();
    check("post_flush_empty", 64'(count), 64'd0);

    // Mid-run reset with count=4, stall=10.
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    rs_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1;
      enq_entry = mk(30 + i, 5);
      tick();
    end
    enq_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("prerst_count", 64'(count), 64'd4);
    check("prerst_stall", 64'(stall_cycles), 64'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_stall", 64'(stall_cycles), 64'd0);
    check("midrst_ready", 64'(enq_ready), 64'd1);
    check("midrst_valid", 64'(disp_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
